// File: rtl/vec_accum.sv
// -----------------------------------------------------------------------------
// vec_accum
//   Reduces each signed product vector to one scalar with an adder tree. It adds
//   those scalars over every beat of a frame and emits one signed dot-product per
//   frame on a valid/ready output.
//   A frame ends on last_i, or is forced closed after MAX_BEATS beats
//   (truncated_o=1).
//
//   Optional feature: define VEC_ACCUM_SAT_EN to clamp every accumulation to the
//   signed OUT_BW range. Without it, accumulation wraps around at OUT_BW bits.
//
// Ports
//   clk_i        clock
//   rstn_i       synchronous active-low reset
//   data_i       VECTOR_SIZE signed BW-bit elements, element i at [(i+1)*BW-1:i*BW]
//   valid_i      input beat valid
//   last_i       final beat of frame (only meaningful on an accepted beat)
//   ready_o      block accepts a beat this cycle
//   data_o       signed frame result
//   valid_o      result valid
//   truncated_o  result closed by MAX_BEATS rather than last_i; qualified by valid_o
//   ready_i      downstream accepts result
// -----------------------------------------------------------------------------
module vec_accum #(
   parameter int unsigned BW          = 8,
   parameter int unsigned VECTOR_SIZE = 13,
   parameter int unsigned OUT_BW      = 24,
   parameter int unsigned MAX_BEATS   = 64
) (
   input  logic                        clk_i,
   input  logic                        rstn_i,
   input  logic [VECTOR_SIZE*BW-1:0]   data_i,
   input  logic                        valid_i,
   input  logic                        last_i,
   output logic                        ready_o,
   output logic [OUT_BW-1:0]           data_o,
   output logic                        valid_o,
   output logic                        truncated_o,
   input  logic                        ready_i
);

   // A one-bit counter is kept even for MAX_BEATS=1; it then never leaves zero.
   localparam int unsigned CntW = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(MAX_BEATS - 1);

   typedef enum logic {S_ACC, S_OUT} state_t;

   state_t            r_state;
   logic [OUT_BW-1:0] r_acc;
   logic [CntW-1:0]   r_beat_cnt;
   logic [OUT_BW-1:0] r_data;
   logic              r_valid;
   logic              r_trunc;

   logic              w_ready;
   logic              w_accept;
   logic              w_close;
   logic [OUT_BW-1:0] w_beat_sum;
   logic [OUT_BW-1:0] w_next;

   assign w_ready  = (r_state == S_ACC) | ((r_state == S_OUT) & ready_i);
   assign w_accept = valid_i & w_ready;
   assign w_close  = last_i | (r_beat_cnt == LastCnt);

   // Adder tree: every element is sign-extended to OUT_BW before summing.
   always_comb begin
      w_beat_sum = '0;
      for (int i = 0; i < int'(VECTOR_SIZE); i++) begin
         w_beat_sum = w_beat_sum + OUT_BW'($signed(data_i[i*BW +: BW]));
      end
   end

   // r_acc is zero whenever a result is held, so a beat taken during the output
   // handshake starts a fresh frame without a separate clear path.
`ifdef VEC_ACCUM_SAT_EN
   logic [OUT_BW:0] w_wide;

   assign w_wide = {r_acc[OUT_BW-1], r_acc} + {w_beat_sum[OUT_BW-1], w_beat_sum};

   // Overflow when the guard bit disagrees with the result sign; the guard bit
   // gives the true sign and selects which rail to clamp to.
   always_comb begin
      w_next = w_wide[OUT_BW-1:0];
      if (w_wide[OUT_BW] != w_wide[OUT_BW-1]) begin
         w_next = w_wide[OUT_BW] ? {1'b1, {(OUT_BW-1){1'b0}}} : {1'b0, {(OUT_BW-1){1'b1}}};
      end
   end
`else
   assign w_next = r_acc + w_beat_sum;
`endif

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         r_state    <= S_ACC;
         r_acc      <= '0;
         r_beat_cnt <= '0;
         r_data     <= '0;
         r_valid    <= 1'b0;
         r_trunc    <= 1'b0;
      end else begin
         // Result consumed; overridden below if this cycle's beat closes a frame.
         if ((r_state == S_OUT) && ready_i) begin
            r_valid <= 1'b0;
            r_state <= S_ACC;
         end
         if (w_accept) begin
            if (w_close) begin
               r_data     <= w_next;
               r_trunc    <= ~last_i;
               r_valid    <= 1'b1;
               r_acc      <= '0;
               r_beat_cnt <= '0;
               r_state    <= S_OUT;
            end else begin
               r_acc      <= w_next;
               r_beat_cnt <= r_beat_cnt + 1'b1;
            end
         end
      end
   end

   assign ready_o     = w_ready;
   assign data_o      = r_data;
   assign valid_o     = r_valid;
   assign truncated_o = r_trunc;

endmodule

// File: tb/tb_vec_accum.sv
// -----------------------------------------------------------------------------
// tb_vec_accum
//   Self-checking bench for vec_accum, built with OUT_BW=12 and MAX_BEATS=4 so
//   that forced termination and overflow are reachable with short frames.
//   Results depend on VEC_ACCUM_SAT_EN in the same way as in the design.
// -----------------------------------------------------------------------------
module tb_vec_accum;

   localparam int BW  = 8;
   localparam int VS  = 13;
   localparam int OBW = 12;
   localparam int MB  = 4;

   logic              clk_i = 1'b0;
   logic              rstn_i;
   logic [VS*BW-1:0]  data_i;
   logic              valid_i;
   logic              last_i;
   logic              ready_o;
   logic [OBW-1:0]    data_o;
   logic              valid_o;
   logic              truncated_o;
   logic              ready_i;

   int total = 0;
   int bad   = 0;

   vec_accum #(
      .BW          (BW),
      .VECTOR_SIZE (VS),
      .OUT_BW      (OBW),
      .MAX_BEATS   (MB)
   ) u_dut (
      .clk_i       (clk_i),
      .rstn_i      (rstn_i),
      .data_i      (data_i),
      .valid_i     (valid_i),
      .last_i      (last_i),
      .ready_o     (ready_o),
      .data_o      (data_o),
      .valid_o     (valid_o),
      .truncated_o (truncated_o),
      .ready_i     (ready_i)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      int e;        // value of every element
      bit v;
      bit l;
      bit r;
      bit x_ready;  // ready_o before the edge
      bit x_valid;  // outputs after the edge
      int x_data;
      bit x_trunc;
   } row_t;

   row_t tab[18];

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int fix(input int v);
      int lo, hi, w;
      lo = -(1 << (OBW - 1));
      hi = (1 << (OBW - 1)) - 1;
`ifdef VEC_ACCUM_SAT_EN
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
`else
      w = v & ((1 << OBW) - 1);
      if (w > hi) w = w - (1 << OBW);
      return w;
`endif
   endfunction

   task automatic set_all(input int e);
      logic [BW-1:0] b;
      b = BW'(e);
      for (int i = 0; i < VS; i++) data_i[i*BW +: BW] = b;
   endtask

   task automatic step(input int e, input bit v, input bit l, input bit r);
      set_all(e);
      valid_i = v;
      last_i  = l;
      ready_i = r;
      @(posedge clk_i);
      #1;
   endtask

   function automatic int sdata();
      return int'($signed(data_o));
   endfunction

   // Reference model state: a held result and the partial frame.
   bit m_have;
   int m_res;
   bit m_trunc;
   int m_acc;
   int m_n;

   initial begin
      int e_sat2, e_sat3;
      int elems[VS];
      int s;
      bit exp_ready, acc;

      // Overflow expectations: 13*127=1651 per beat, 13*-128=-1664.
      e_sat2 = fix(fix(1651) + 1651);
      e_sat3 = fix(fix(fix(1651) + 1651) - 1664);

      tab[0]  = '{1,  1, 1, 1, 1, 1, 13, 0};   // single-beat frame
      tab[1]  = '{2,  1, 0, 1, 1, 0, 0,  0};   // handshake + new frame starts
      tab[2]  = '{-1, 1, 0, 1, 1, 0, 0,  0};
      tab[3]  = '{5,  1, 1, 1, 1, 1, 78, 0};   // 13*(2-1+5)
      tab[4]  = '{0,  0, 0, 1, 1, 0, 0,  0};
      tab[5]  = '{1,  1, 0, 0, 1, 0, 0,  0};   // forced termination after 4 beats
      tab[6]  = '{1,  1, 0, 0, 1, 0, 0,  0};
      tab[7]  = '{1,  1, 0, 0, 1, 0, 0,  0};
      tab[8]  = '{1,  1, 0, 0, 1, 1, 52, 1};
      tab[9]  = '{1,  1, 0, 1, 1, 0, 0,  0};   // 5th beat opens a new frame
      tab[10] = '{2,  1, 1, 0, 1, 1, 39, 0};
      tab[11] = '{7,  1, 1, 0, 0, 1, 39, 0};   // back-pressure: held stable
      tab[12] = '{7,  1, 1, 0, 0, 1, 39, 0};
      tab[13] = '{7,  1, 1, 0, 0, 1, 39, 0};
      tab[14] = '{7,  1, 1, 0, 0, 1, 39, 0};
      tab[15] = '{7,  1, 1, 0, 0, 1, 39, 0};
      tab[16] = '{7,  1, 1, 1, 1, 1, 91, 0};   // one-beat frame during handshake
      tab[17] = '{0,  0, 0, 1, 1, 0, 0,  0};

      rstn_i = 1'b0;
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      chk("reset_valid", int'(valid_o), 0);
      chk("reset_data", sdata(), 0);
      chk("reset_trunc", int'(truncated_o), 0);
      rstn_i = 1'b1;
      step(0, 0, 0, 0);
      chk("idle_ready", int'(ready_o), 1);

      for (int k = 0; k < 18; k++) begin
         set_all(tab[k].e);
         valid_i = tab[k].v;
         last_i  = tab[k].l;
         ready_i = tab[k].r;
         @(negedge clk_i);
         chk($sformatf("tab%0d_ready", k), int'(ready_o), int'(tab[k].x_ready));
         @(posedge clk_i);
         #1;
         chk($sformatf("tab%0d_valid", k), int'(valid_o), int'(tab[k].x_valid));
         if (tab[k].x_valid) begin
            chk($sformatf("tab%0d_data", k), sdata(), tab[k].x_data);
            chk($sformatf("tab%0d_trunc", k), int'(truncated_o), int'(tab[k].x_trunc));
         end
      end

      // Overflow: two and three beat frames near the rails.
      step(127, 1, 0, 1);
      step(127, 1, 1, 1);
      chk("ovf2_valid", int'(valid_o), 1);
      chk("ovf2_data", sdata(), e_sat2);
      step(127, 1, 0, 1);
      step(127, 1, 0, 1);
      step(-128, 1, 1, 1);
      chk("ovf3_data", sdata(), e_sat3);

      // Reset mid-frame drops the partial sum.
      step(0, 0, 0, 1);
      step(9, 1, 0, 1);
      step(9, 1, 0, 1);
      rstn_i = 1'b0;
      step(9, 1, 0, 1);
      rstn_i = 1'b1;
      chk("midrst_valid", int'(valid_o), 0);
      chk("midrst_ready", int'(ready_o), 1);
      step(3, 1, 1, 1);
      chk("midrst_valid2", int'(valid_o), 1);
      chk("midrst_data", sdata(), 39);
      chk("midrst_trunc", int'(truncated_o), 0);

      // Reset while holding a result.
      rstn_i = 1'b0;
      step(0, 0, 0, 0);
      rstn_i = 1'b1;
      chk("holdrst_valid", int'(valid_o), 0);

      // Randomized traffic against the frame-level model.
      m_have = 0; m_res = 0; m_trunc = 0; m_acc = 0; m_n = 0;
      for (int c = 0; c < 3000; c++) begin
         bit wide;
         wide = ($urandom_range(0, 3) == 0);
         s = 0;
         for (int i = 0; i < VS; i++) begin
            elems[i] = wide ? $urandom_range(0, 255) - 128 : $urandom_range(0, 16) - 8;
            data_i[i*BW +: BW] = BW'(elems[i]);
            s += elems[i];
         end
         valid_i = ($urandom_range(0, 3) != 0);
         last_i  = ($urandom_range(0, 3) == 0);
         ready_i = ($urandom_range(0, 2) != 0);
         @(negedge clk_i);
         exp_ready = !m_have || ready_i;
         chk("rnd_ready", int'(ready_o), int'(exp_ready));
         chk("rnd_valid", int'(valid_o), int'(m_have));
         if (m_have && valid_o) begin
            chk("rnd_data", sdata(), m_res);
            chk("rnd_trunc", int'(truncated_o), int'(m_trunc));
         end
         acc = valid_i && exp_ready;
         if (m_have && ready_i) m_have = 0;
         if (acc) begin
            m_acc = fix(m_acc + s);
            m_n++;
            if (last_i || m_n == MB) begin
               m_res   = m_acc;
               m_trunc = !last_i;
               m_have  = 1;
               m_acc   = 0;
               m_n     = 0;
            end
         end
         @(posedge clk_i);
         #1;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
